uart_job_deframer: RTL and testbench
====================================

// Module: uart_job_deframer
// PURPOSE
//  Consumes the byte stream from the UART receiver (received/rx_byte/recv_error) and assembles host frames
//  [SYNC][CMD][LEN][payload x LEN][CSUM] into one wide job word for the K12 hashing core.
//  Validates length and XOR checksum and enforces an inter-byte timeout.
//  Presents the job on a valid/ready handshake and reports per-frame errors as single-cycle pulses.
// PARAMETERS
//  MAX_PAYLOAD     84        max payload bytes; sets job_data width = 8*MAX_PAYLOAD
//  SYNC_BYTE       8'hA5     frame start marker
//  TIMEOUT_CYCLES  2000000   clk cycles allowed between bytes inside a frame (20 ms @ 100 MHz); >= 2
// PORTS
//  clk         in   1               master clock
//  rst         in   1               asynchronous reset, active-low (asserted when 0)
//  rx_valid    in   1               one-cycle strobe; connect to UART received
//  rx_data     in   8               byte received; sampled only when rx_valid = 1
//  rx_error    in   1               one-cycle strobe; connect to UART recv_error
//  job_valid   out  1               job_cmd/job_len/job_data hold a complete, checked frame
//  job_ready   in   1               consumer accepts the job on the cycle job_valid & job_ready
//  job_cmd     out  8               CMD byte of the frame
//  job_len     out  8               payload byte count, 1..MAX_PAYLOAD
//  job_data    out  8*MAX_PAYLOAD   payload; byte i at [8*i+:8]; bytes >= job_len are 0
//  err_valid   out  1               one-cycle error strobe
//  err_code    out  2               1 = bad checksum, 2 = bad LEN, 3 = timeout or line error; valid with err_valid
// BEHAVIOUR
//  Reset: state = S_SYNC. All outputs are 0, job_data = 0, timeout counter = 0.
//  States and transitions; every transition happens on the rx_valid cycle:
//  - S_SYNC: rx_data == SYNC_BYTE -> S_CMD and csum = 0. Any other byte is discarded silently.
//  - S_CMD: job_cmd <= byte; csum ^= byte; -> S_LEN.
//  - S_LEN:
//      byte == 0 or byte > MAX_PAYLOAD -> err 2, -> S_SYNC.
//      Otherwise job_len <= byte, job_data <= 0, idx = 0, csum ^= byte, -> S_PAY.
//  - S_PAY: job_data[8*idx+:8] <= byte; csum ^= byte; idx++. When idx == job_len-1 -> S_CSUM.
//  - S_CSUM:
//      byte == csum -> job_valid <= 1, -> S_HOLD.
//      Otherwise err 1, -> S_SYNC. job_valid stays 0.
//  - S_HOLD: job_valid = 1. All incoming bytes are ignored, with no error.
//      When job_valid & job_ready -> job_valid <= 0 on the next edge, -> S_SYNC.
//  Outputs are registered. The job becomes visible 1 cycle after the CSUM byte strobe.
//  job_* values are stable while job_valid = 1.
//  Timeout:
//  - The counter clears on every rx_valid and in S_SYNC and S_HOLD. It increments in S_CMD..S_CSUM.
//  - Reaching TIMEOUT_CYCLES-1 -> err 3, -> S_SYNC.
//  - rx_valid on the same cycle as expiry: the byte wins and the counter clears.
//  rx_error:
//  - In S_CMD..S_CSUM -> err 3, -> S_SYNC.
//  - In S_SYNC and S_HOLD it is ignored.
//  - rx_error on the same cycle as rx_valid: rx_error wins and the byte is dropped.
//  err_valid is high for exactly 1 cycle per error, registered, and is never raised in S_HOLD.
//  A partial frame abandoned by an error leaves job_cmd/job_len/job_data undefined, but job_valid = 0.
//  Reset asserted mid-frame or mid-hold: immediate return to S_SYNC with all outputs 0. No job is delivered.
//  Widths:
//  - idx is $clog2(MAX_PAYLOAD) bits.
//  - LEN is compared as 8-bit unsigned. MAX_PAYLOAD <= 255 is required.
//  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps.
// STRUCTURE
//  Shared package uart_pkg holds:
//  - state encodings S_SYNC/S_CMD/S_LEN/S_PAY/S_CSUM/S_HOLD
//  - err codes ERR_CSUM=1, ERR_LEN=2, ERR_LINE=3
//  - default SYNC_BYTE
//  One sub-module, uart_timeout_ctr: clear/enable inputs, expire output, TIMEOUT_CYCLES parameter.
//  Reused later by the result framer on the transmit side. All else is a single FSM plus datapath.
// TESTING
//  1. A5 01 02 11 22 30 -> job_valid=1 one cycle after last strobe, job_cmd=01, job_len=02,
//     job_data[15:0]=2211, upper bytes 0, err_valid never.
//  2. A5 01 02 11 22 31 -> err_valid pulse with err_code=1, job_valid stays 0;
//     a following good frame from test 1 is accepted.
//  3. A5 01 00 and, separately, A5 01 55 with MAX_PAYLOAD=84 -> err_code=2 each time, state back to S_SYNC.
//  4. A5 01 then silence for TIMEOUT_CYCLES -> err_code=3 exactly once;
//     a byte arriving on the expiry cycle instead -> no error.
//  5. Good frame with job_ready=0 held for 1000 cycles while a second full frame arrives -> second frame ignored,
//     no err; the first job is held unchanged; job_ready=1 -> job_valid falls next cycle.
//  6. Reset pulsed after A5 01 04 11 -> all outputs 0; the remaining 22 33 44 xx bytes produce no job and no error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART host-link framers: FSM states, error codes and the default sync marker.
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CSUM = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_LINE = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry at TIMEOUT_CYCLES-1.
module uart_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at the terminal count so the counter can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TC)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && !clear && (count == TC);

endmodule

// File: rtl/uart_job_deframer.sv
// Assembles [SYNC][CMD][LEN][payload][CSUM] host frames into one job word for the hashing core,
// checking length, XOR checksum and inter-byte timeout, with a valid/ready job port and error strobes.
//
// state  | meaning
// S_SYNC | hunting for the sync marker, other bytes dropped
// S_CMD  | expecting the command byte
// S_LEN  | expecting the payload length
// S_PAY  | collecting payload bytes
// S_CSUM | expecting the XOR checksum
// S_HOLD | job presented, waiting for the consumer
module uart_job_deframer
    import uart_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 84,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_error,
    output logic                       job_valid,
    input  logic                       job_ready,
    output logic [7:0]                 job_cmd,
    output logic [7:0]                 job_len,
    output logic [8*MAX_PAYLOAD-1:0]   job_data,
    output logic                       err_valid,
    output logic [1:0]                 err_code
);
    localparam int         IW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t        state;
    logic [7:0]    csum;
    logic [IW-1:0] idx;
    logic          mid_frame;
    logic          byte_ok;
    logic          tmo_expire;

    assign mid_frame = (state == S_CMD) || (state == S_LEN) || (state == S_PAY) || (state == S_CSUM);
    // A line error on the same strobe poisons the byte.
    assign byte_ok   = rx_valid && !rx_error;

    uart_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || !mid_frame),
        .enable (mid_frame),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_SYNC;
            csum      <= '0;
            idx       <= '0;
            job_valid <= 1'b0;
            job_cmd   <= '0;
            job_len   <= '0;
            job_data  <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            err_valid <= 1'b0;
            if (mid_frame && (rx_error || tmo_expire)) begin
                err_valid <= 1'b1;
                err_code  <= ERR_LINE;
                state     <= S_SYNC;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (byte_ok && (rx_data == SYNC_BYTE)) begin
                            csum  <= '0;
                            state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (byte_ok) begin
                            job_cmd <= rx_data;
                            csum    <= csum ^ rx_data;
                            state   <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (byte_ok) begin
                            if ((rx_data == 8'd0) || (rx_data > MAX_LEN)) begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_LEN;
                                state     <= S_SYNC;
                            end else begin
                                job_len  <= rx_data;
                                job_data <= '0;
                                idx      <= '0;
                                csum     <= csum ^ rx_data;
                                state    <= S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        if (byte_ok) begin
                            job_data[{idx, 3'b000} +: 8] <= rx_data;
                            csum <= csum ^ rx_data;
                            idx  <= idx + IW'(1);
                            if (8'(idx) == (job_len - 8'd1)) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (byte_ok) begin
                            if (rx_data == csum) begin
                                job_valid <= 1'b1;
                                state     <= S_HOLD;
                            end else begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_CSUM;
                                state     <= S_SYNC;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (job_ready) begin
                            job_valid <= 1'b0;
                            state     <= S_SYNC;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_job_deframer.sv
// Bench for uart_job_deframer: directed frame scenarios plus a random byte stream, checked every cycle
// against a queue-based frame model.
module tb_uart_job_deframer;
    localparam int         MAXP = 84;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 50;
    localparam int         DW   = 8 * MAXP;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_error;
    logic          job_valid;
    logic          job_ready;
    logic [7:0]    job_cmd;
    logic [7:0]    job_len;
    logic [DW-1:0] job_data;
    logic          err_valid;
    logic [1:0]    err_code;

    uart_job_deframer #(
        .MAX_PAYLOAD   (MAXP),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_cmd   (job_cmd),
        .job_len   (job_len),
        .job_data  (job_data),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: bytes of the frame in progress, plus a flag for a job awaiting acceptance.
    logic [7:0]    m_frame[$];
    bit            m_hold;
    int            m_idle;
    logic          exp_job_valid;
    logic          exp_err_valid;
    logic [1:0]    exp_err_code;
    logic [7:0]    exp_cmd;
    logic [7:0]    exp_len;
    logic [DW-1:0] exp_data;

    task model_abort(input logic [1:0] code);
        exp_err_valid = 1'b1;
        exp_err_code  = code;
        m_frame.delete();
    endtask

    task model_eval;
        int n;
        int len;
        logic [7:0] x;
        n = m_frame.size();
        if (n < 3) return;
        len = int'(m_frame[2]);
        if (n == 3 && (len == 0 || len > MAXP)) begin
            model_abort(2'd2);
        end else if (n == len + 4) begin
            x = 8'h00;
            for (int i = 1; i < n - 1; i++) x = x ^ m_frame[i];
            if (x == m_frame[n-1]) begin
                m_hold        = 1'b1;
                exp_job_valid = 1'b1;
                exp_cmd       = m_frame[1];
                exp_len       = m_frame[2];
                exp_data      = '0;
                for (int i = 0; i < len; i++) exp_data[8*i +: 8] = m_frame[3+i];
                m_frame.delete();
            end else begin
                model_abort(2'd1);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_frame.delete();
            m_hold        = 1'b0;
            m_idle        = 0;
            exp_job_valid = 1'b0;
            exp_err_valid = 1'b0;
            exp_err_code  = 2'd0;
            exp_cmd       = 8'd0;
            exp_len       = 8'd0;
            exp_data      = '0;
        end else begin
            exp_err_valid = 1'b0;
            if (m_hold) begin
                if (job_ready) begin
                    m_hold        = 1'b0;
                    exp_job_valid = 1'b0;
                end
            end else if (m_frame.size() == 0) begin
                if (rx_valid && !rx_error && rx_data == SYNC) begin
                    m_frame.push_back(rx_data);
                    m_idle = 0;
                end
            end else if (rx_error) begin
                model_abort(2'd3);
            end else if (rx_valid) begin
                m_idle = 0;
                m_frame.push_back(rx_data);
                model_eval();
            end else begin
                m_idle++;
                if (m_idle >= TMO) model_abort(2'd3);
            end
        end
    end

    always @(negedge clk) begin
        chk("job_valid", job_valid, exp_job_valid);
        chk("err_valid", err_valid, exp_err_valid);
        if (exp_err_valid) chk("err_code", err_code, exp_err_code);
        if (exp_job_valid) begin
            chk("job_cmd", job_cmd, exp_cmd);
            chk("job_len", job_len, exp_len);
            chk("job_data", job_data, exp_data);
        end
        if (err_valid) err_seen++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    logic [7:0] seq[$];

    task automatic send_seq;
        for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
    endtask

    task automatic release_job;
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        chk("release_drops_valid", job_valid, 1'b0);
    endtask

    task automatic check_good_t1(input string tag);
        chk({tag, "_valid"}, job_valid, 1'b1);
        chk({tag, "_cmd"}, job_cmd, 8'h01);
        chk({tag, "_len"}, job_len, 8'h02);
        chk({tag, "_data"}, job_data, 672'h2211);
    endtask

    logic [7:0] stream[$];

    task automatic build_random_stream(input int n_frames);
        for (int f = 0; f < n_frames; f++) begin
            int kind;
            int len;
            logic [7:0] cmd;
            logic [7:0] x;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            if (kind == 8) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) stream.push_back(8'($urandom));
            end else if (kind == 7) begin
                stream.push_back(SYNC);
                stream.push_back(8'($urandom));
                stream.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXP + 1, 255)));
            end else begin
                case ($urandom_range(0, 3))
                    0:       len = MAXP;
                    1:       len = 1;
                    2:       len = $urandom_range(1, MAXP);
                    default: len = $urandom_range(1, 8);
                endcase
                cmd = 8'($urandom);
                x   = cmd ^ 8'(len);
                stream.push_back(SYNC);
                stream.push_back(cmd);
                stream.push_back(8'(len));
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    stream.push_back(b);
                end
                if (kind == 6) x = x ^ (8'h01 << $urandom_range(0, 7));
                stream.push_back(x);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_error  = 1'b0;
        job_ready = 1'b0;
        tick();
        tick();
        chk("reset_job_valid", job_valid, 1'b0);
        chk("reset_err_valid", err_valid, 1'b0);
        chk("reset_job_data", job_data, '0);
        rst = 1'b1;
        tick();

        // Test 1: good frame
        e0  = err_seen;
        seq = {8'hA5, 8'h01, 8'h02, 8'h11, 8'h22};
        send_seq();
        chk("t1_not_early", job_valid, 1'b0);
        send_byte(8'h30);
        check_good_t1("t1");
        chk("t1_model_data", exp_data, 672'h2211);
        chk("t1_model_valid", exp_job_valid, 1'b1);
        release_job();
        chk("t1_no_err", err_seen, e0);

        // Test 2: bad checksum then recovery
        seq = {8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
        send_seq();
        chk("t2_err_valid", err_valid, 1'b1);
        chk("t2_err_code", err_code, 2'd1);
        chk("t2_job_valid", job_valid, 1'b0);
        seq = {8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        send_seq();
        check_good_t1("t2_recover");
        release_job();

        // Test 3: bad lengths
        seq = {8'hA5, 8'h01, 8'h00};
        send_seq();
        chk("t3_len0_err", err_valid, 1'b1);
        chk("t3_len0_code", err_code, 2'd2);
        seq = {8'hA5, 8'h01, 8'h55};
        send_seq();
        chk("t3_len85_err", err_valid, 1'b1);
        chk("t3_len85_code", err_code, 2'd2);
        chk("t3_model_code", exp_err_code, 2'd2);

        // Test 4: timeout, then a byte landing on the expiry cycle
        tick();
        e0  = err_seen;
        seq = {8'hA5, 8'h01};
        send_seq();
        repeat (TMO - 1) tick();
        chk("t4_not_early", err_valid, 1'b0);
        tick();
        chk("t4_tmo_err", err_valid, 1'b1);
        chk("t4_tmo_code", err_code, 2'd3);
        tick();
        tick();
        chk("t4_once", err_seen, e0 + 1);
        seq = {8'hA5, 8'h01};
        send_seq();
        repeat (TMO - 1) tick();
        send_byte(8'h02);
        chk("t4_byte_wins", err_valid, 1'b0);
        seq = {8'h11, 8'h22, 8'h30};
        send_seq();
        check_good_t1("t4_after");
        chk("t4_no_err", err_seen, e0 + 1);
        release_job();

        // Test 5: job held for 1000 cycles while another frame arrives
        e0  = err_seen;
        seq = {8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        send_seq();
        seq = {8'hA5, 8'h07, 8'h01, 8'h99, 8'h9F};
        for (int i = 0; i < 1000; i++) begin
            if (i % 150 == 0 && i / 150 < seq.size()) begin
                rx_valid = 1'b1;
                rx_data  = seq[i / 150];
            end
            tick();
            rx_valid = 1'b0;
        end
        check_good_t1("t5_held");
        chk("t5_no_err", err_seen, e0);
        release_job();

        // Test 6: reset mid-frame
        seq = {8'hA5, 8'h01, 8'h04, 8'h11};
        send_seq();
        chk("t6_cmd_before", job_cmd, 8'h01);
        rst = 1'b0;
        #2;
        chk("t6_rst_cmd", job_cmd, 8'h00);
        chk("t6_rst_len", job_len, 8'h00);
        chk("t6_rst_valid", job_valid, 1'b0);
        chk("t6_rst_err", err_valid, 1'b0);
        tick();
        rst = 1'b1;
        e0  = err_seen;
        seq = {8'h22, 8'h33, 8'h44, 8'h5C};
        send_seq();
        repeat (TMO + 5) tick();
        chk("t6_no_job", job_valid, 1'b0);
        chk("t6_no_err", err_seen, e0);

        // Random stream with random gaps, line errors and back-pressure
        build_random_stream(90);
        for (int i = 0; i < stream.size(); i++) begin
            int r;
            int g;
            r = $urandom_range(0, 99);
            if (r < 70)      g = $urandom_range(0, 2);
            else if (r < 94) g = $urandom_range(3, 10);
            else if (r < 97) g = TMO - 1;
            else             g = TMO + $urandom_range(0, 3);
            repeat (g) begin
                job_ready = ($urandom_range(0, 3) == 0);
                rx_error  = ($urandom_range(0, 299) == 0);
                tick();
                rx_error = 1'b0;
            end
            job_ready = ($urandom_range(0, 3) == 0);
            rx_error  = ($urandom_range(0, 499) == 0);
            send_byte(stream[i]);
            rx_error = 1'b0;
        end
        job_ready = 1'b1;
        repeat (TMO + 5) tick();
        job_ready = 1'b0;
        chk("final_idle", job_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
